// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter between NUM_UNITS compute units and the shared vector (port A)
// and matrix (port B) memories. One transaction at a time, every output registered,
// with a busy-timeout watchdog and a sticky error cause.
module shared_mem_arbiter #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned UID_W     = $clog2(NUM_UNITS),
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned VADDR_W   = UID_W + IDX_W,
    parameter int unsigned MROW_W    = 4,
    parameter int unsigned MCOL_W    = 4,
    parameter int unsigned MDATA_W   = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_UNITS-1:0]          unit_req,
    input  logic [NUM_UNITS*2-1:0]        unit_op,
    input  logic [NUM_UNITS*IDX_W-1:0]    unit_vidx,
    input  logic [NUM_UNITS*MROW_W-1:0]   unit_mrow,
    input  logic [NUM_UNITS*MCOL_W-1:0]   unit_mcol,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_wdata,
    output logic [NUM_UNITS-1:0]          unit_grant,
    output logic [NUM_UNITS-1:0]          unit_done,
    output logic [NUM_UNITS-1:0]          unit_err,
    output logic [NUM_UNITS*DATA_W-1:0]   unit_rdata,
    output logic [1:0]                    err_code,
    output logic [VADDR_W-1:0]            mem_addr_a,
    output logic                          mem_we_a,
    output logic [DATA_W-1:0]             mem_wdata_a,
    input  logic [DATA_W-1:0]             mem_rdata_a,
    output logic [MROW_W+MCOL_W-1:0]      mem_addr_b,
    output logic                          mem_we_b,
    output logic [MDATA_W-1:0]            mem_wdata_b,
    input  logic [MDATA_W-1:0]            mem_rdata_b,
    input  logic                          mem_busy,
    input  logic [1:0]                    mem_error
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned MADDR_W = MROW_W + MCOL_W;

    localparam logic [1:0] OpLoadV  = 2'b00;
    localparam logic [1:0] OpStoreV = 2'b01;
    localparam logic [1:0] OpLoadM  = 2'b10;
    localparam logic [1:0] OpStoreM = 2'b11;

    localparam logic [1:0] ErrMem     = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StAccess,
        StWait,
        StDone,
        StError
    } state_e;

    // Per-unit views of the packed request buses
    logic [1:0]         w_op    [NUM_UNITS];
    logic [IDX_W-1:0]   w_vidx  [NUM_UNITS];
    logic [MROW_W-1:0]  w_mrow  [NUM_UNITS];
    logic [MCOL_W-1:0]  w_mcol  [NUM_UNITS];
    logic [DATA_W-1:0]  w_wdata [NUM_UNITS];

    // State and output registers
    state_e               r_state;
    logic [UID_W-1:0]     r_rr_ptr;
    logic [UID_W-1:0]     r_sel;
    logic [1:0]           r_op;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_UNITS-1:0] r_grant;
    logic [NUM_UNITS-1:0] r_done;
    logic [NUM_UNITS-1:0] r_err;
    logic [DATA_W-1:0]    r_rdata [NUM_UNITS];
    logic [1:0]           r_err_code;
    logic [VADDR_W-1:0]   r_addr_a;
    logic                 r_we_a;
    logic [DATA_W-1:0]    r_wdata_a;
    logic [MADDR_W-1:0]   r_addr_b;
    logic                 r_we_b;
    logic [MDATA_W-1:0]   r_wdata_b;

    // Next-state values
    state_e               w_state_nxt;
    logic [UID_W-1:0]     w_rr_nxt;
    logic [UID_W-1:0]     w_sel_nxt;
    logic [1:0]           w_op_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [NUM_UNITS-1:0] w_grant_nxt;
    logic [NUM_UNITS-1:0] w_done_nxt;
    logic [NUM_UNITS-1:0] w_err_nxt;
    logic [DATA_W-1:0]    w_rdata_nxt [NUM_UNITS];
    logic [1:0]           w_err_code_nxt;
    logic [VADDR_W-1:0]   w_addr_a_nxt;
    logic                 w_we_a_nxt;
    logic [DATA_W-1:0]    w_wdata_a_nxt;
    logic [MADDR_W-1:0]   w_addr_b_nxt;
    logic                 w_we_b_nxt;
    logic [MDATA_W-1:0]   w_wdata_b_nxt;

    // Round-robin scan results
    logic                 w_found;
    logic [UID_W-1:0]     w_pick;
    logic [UID_W-1:0]     w_scan;
    logic [1:0]           w_pick_op;
    logic [NUM_UNITS-1:0] w_pick_oh;
    logic [NUM_UNITS-1:0] w_sel_oh;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
        assign w_op[g]    = unit_op[g*2 +: 2];
        assign w_vidx[g]  = unit_vidx[g*IDX_W +: IDX_W];
        assign w_mrow[g]  = unit_mrow[g*MROW_W +: MROW_W];
        assign w_mcol[g]  = unit_mcol[g*MCOL_W +: MCOL_W];
        assign w_wdata[g] = unit_wdata[g*DATA_W +: DATA_W];
        assign unit_rdata[g*DATA_W +: DATA_W] = r_rdata[g];
    end

    assign w_pick_op = w_op[w_pick];
    assign w_pick_oh = NUM_UNITS'(1) << w_pick;
    assign w_sel_oh  = NUM_UNITS'(1) << r_sel;

    // Pick the first requester at or after rr_ptr, wrapping modulo NUM_UNITS
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            w_scan = UID_W'((int'(r_rr_ptr) + i) % int'(NUM_UNITS));
            if (!w_found && unit_req[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
        end
    end

    // FSM next-state and next values of every registered output
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr_ptr;
        w_sel_nxt      = r_sel;
        w_op_nxt       = r_op;
        w_cnt_nxt      = r_cnt;
        w_grant_nxt    = r_grant;
        w_done_nxt     = '0;
        w_err_nxt      = '0;
        w_rdata_nxt    = r_rdata;
        w_err_code_nxt = r_err_code;
        w_addr_a_nxt   = r_addr_a;
        w_we_a_nxt     = 1'b0;
        w_wdata_a_nxt  = r_wdata_a;
        w_addr_b_nxt   = r_addr_b;
        w_we_b_nxt     = 1'b0;
        w_wdata_b_nxt  = r_wdata_b;

        unique case (r_state)
            StIdle: begin
                if (|unit_req) begin
                    w_state_nxt = StArb;
                end
            end
            StArb: begin
                if (w_found) begin
                    w_sel_nxt    = w_pick;
                    w_op_nxt     = w_pick_op;
                    w_rr_nxt     = (w_pick == UID_W'(NUM_UNITS - 1)) ? '0 : w_pick + UID_W'(1);
                    w_addr_a_nxt = {w_pick, w_vidx[w_pick]};
                    w_addr_b_nxt = {w_mrow[w_pick], w_mcol[w_pick]};
                    w_grant_nxt  = w_pick_oh;
                    if (w_pick_op == OpStoreV) begin
                        w_we_a_nxt    = 1'b1;
                        w_wdata_a_nxt = w_wdata[w_pick];
                    end
                    if (w_pick_op == OpStoreM) begin
                        w_we_b_nxt    = 1'b1;
                        w_wdata_b_nxt = w_wdata[w_pick][MDATA_W-1:0];
                    end
                    w_state_nxt = StAccess;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StAccess: begin
                if (|mem_error) begin
                    w_err_code_nxt = ErrMem;
                    w_err_nxt      = w_sel_oh;
                    w_grant_nxt    = '0;
                    w_state_nxt    = StError;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                // A memory fault outranks both completion and timeout
                if (|mem_error) begin
                    w_err_code_nxt = ErrMem;
                    w_err_nxt      = w_sel_oh;
                    w_grant_nxt    = '0;
                    w_state_nxt    = StError;
                end else if (!mem_busy) begin
                    if (r_op == OpLoadV) begin
                        w_rdata_nxt[r_sel] = mem_rdata_a;
                    end else if (r_op == OpLoadM) begin
                        w_rdata_nxt[r_sel] = DATA_W'(mem_rdata_b);
                    end
                    w_done_nxt  = w_sel_oh;
                    w_grant_nxt = '0;
                    w_state_nxt = StDone;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This busy cycle is the TIMEOUT-th in a row
                    w_err_code_nxt = ErrTimeout;
                    w_err_nxt      = w_sel_oh;
                    w_grant_nxt    = '0;
                    w_state_nxt    = StError;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            StError: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_err      <= '0;
            for (int i = 0; i < int'(NUM_UNITS); i++) begin
                r_rdata[i] <= '0;
            end
            r_err_code <= '0;
            r_addr_a   <= '0;
            r_we_a     <= 1'b0;
            r_wdata_a  <= '0;
            r_addr_b   <= '0;
            r_we_b     <= 1'b0;
            r_wdata_b  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_sel      <= w_sel_nxt;
            r_op       <= w_op_nxt;
            r_cnt      <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err_code <= w_err_code_nxt;
            r_addr_a   <= w_addr_a_nxt;
            r_we_a     <= w_we_a_nxt;
            r_wdata_a  <= w_wdata_a_nxt;
            r_addr_b   <= w_addr_b_nxt;
            r_we_b     <= w_we_b_nxt;
            r_wdata_b  <= w_wdata_b_nxt;
        end
    end

    assign unit_grant  = r_grant;
    assign unit_done   = r_done;
    assign unit_err    = r_err;
    assign err_code    = r_err_code;
    assign mem_addr_a  = r_addr_a;
    assign mem_we_a    = r_we_a;
    assign mem_wdata_a = r_wdata_a;
    assign mem_addr_b  = r_addr_b;
    assign mem_we_b    = r_we_b;
    assign mem_wdata_b = r_wdata_b;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: latency, load/store routing, round-robin order,
// timeout, error priority and reset mid-transaction.
module tb_shared_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   unit_req;
    logic [7:0]   unit_op;
    logic [15:0]  unit_vidx;
    logic [15:0]  unit_mrow;
    logic [15:0]  unit_mcol;
    logic [127:0] unit_wdata;
    logic [3:0]   unit_grant;
    logic [3:0]   unit_done;
    logic [3:0]   unit_err;
    logic [127:0] unit_rdata;
    logic [1:0]   err_code;
    logic [5:0]   mem_addr_a;
    logic         mem_we_a;
    logic [31:0]  mem_wdata_a;
    logic [31:0]  mem_rdata_a;
    logic [7:0]   mem_addr_b;
    logic         mem_we_b;
    logic [1:0]   mem_wdata_b;
    logic [1:0]   mem_rdata_b;
    logic         mem_busy;
    logic [1:0]   mem_error;

    logic [31:0] vmem [64];
    logic [1:0]  mmem [256];

    int checks = 0;
    int errors = 0;

    shared_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .unit_req    (unit_req),
        .unit_op     (unit_op),
        .unit_vidx   (unit_vidx),
        .unit_mrow   (unit_mrow),
        .unit_mcol   (unit_mcol),
        .unit_wdata  (unit_wdata),
        .unit_grant  (unit_grant),
        .unit_done   (unit_done),
        .unit_err    (unit_err),
        .unit_rdata  (unit_rdata),
        .err_code    (err_code),
        .mem_addr_a  (mem_addr_a),
        .mem_we_a    (mem_we_a),
        .mem_wdata_a (mem_wdata_a),
        .mem_rdata_a (mem_rdata_a),
        .mem_addr_b  (mem_addr_b),
        .mem_we_b    (mem_we_b),
        .mem_wdata_b (mem_wdata_b),
        .mem_rdata_b (mem_rdata_b),
        .mem_busy    (mem_busy),
        .mem_error   (mem_error)
    );

    always #5 clk = ~clk;

    assign mem_rdata_a = vmem[mem_addr_a];
    assign mem_rdata_b = mmem[mem_addr_b];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample on the falling edge; pulses and grants must stay one-hot
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("onehot_grant", 64'($onehot0(unit_grant)), 64'd1);
        chk("onehot_done", 64'($onehot0(unit_done)), 64'd1);
        chk("onehot_err", 64'($onehot0(unit_err)), 64'd1);
    endtask

    task automatic wait_pulse(input int limit, output logic [3:0] d, output logic [3:0] e,
                              output int cyc);
        d   = '0;
        e   = '0;
        cyc = 0;
        while (cyc < limit && d == 4'd0 && e == 4'd0) begin
            tick();
            cyc++;
            d = unit_done;
            e = unit_err;
        end
    endtask

    task automatic set_unit(input int u, input logic [1:0] op, input logic [3:0] vidx,
                            input logic [3:0] row, input logic [3:0] col,
                            input logic [31:0] wd);
        unit_op[u*2 +: 2]     = op;
        unit_vidx[u*4 +: 4]   = vidx;
        unit_mrow[u*4 +: 4]   = row;
        unit_mcol[u*4 +: 4]   = col;
        unit_wdata[u*32 +: 32] = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [3:0] d;
        logic [3:0] e;
        int cyc;
        int cnt [4];
        int u;
        logic [31:0] old3;

        rst        = 1'b1;
        unit_req   = '0;
        unit_op    = '0;
        unit_vidx  = '0;
        unit_mrow  = '0;
        unit_mcol  = '0;
        unit_wdata = '0;
        mem_busy   = 1'b0;
        mem_error  = 2'b00;
        for (int i = 0; i < 64; i++) vmem[i] = 32'hA500_0000 | 32'(i);
        for (int i = 0; i < 256; i++) mmem[i] = 2'(i);
        vmem[6'h25] = 32'hDEAD_BEEF;
        mmem[8'h47] = 2'b11;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 64'(unit_grant), 64'h0);
        chk("rst_done", 64'(unit_done), 64'h0);
        chk("rst_err", 64'(unit_err), 64'h0);
        chk("rst_rdata", 64'(|unit_rdata), 64'h0);
        chk("rst_err_code", 64'(err_code), 64'h0);
        chk("rst_addr_a", 64'(mem_addr_a), 64'h0);
        chk("rst_addr_b", 64'(mem_addr_b), 64'h0);
        chk("rst_we", 64'({mem_we_a, mem_we_b}), 64'h0);
        rst = 1'b0;
        tick();

        // LOAD_V from unit 2, vidx 5
        set_unit(2, 2'b00, 4'd5, 4'd0, 4'd0, 32'h0);
        unit_req = 4'b0100;
        tick();
        chk("lv_arb_grant", 64'(unit_grant), 64'h0);
        tick();
        chk("lv_acc_grant", 64'(unit_grant), 64'h4);
        chk("lv_acc_addr_a", 64'(mem_addr_a), 64'h25);
        chk("lv_acc_we", 64'({mem_we_a, mem_we_b}), 64'h0);
        unit_req = 4'b0000;
        set_unit(2, 2'b01, 4'd7, 4'd0, 4'd0, 32'h0);
        tick();
        chk("lv_wait_grant", 64'(unit_grant), 64'h4);
        chk("lv_wait_addr_a", 64'(mem_addr_a), 64'h25);
        chk("lv_wait_done", 64'(unit_done), 64'h0);
        tick();
        chk("lv_done", 64'(unit_done), 64'h4);
        chk("lv_done_grant", 64'(unit_grant), 64'h0);
        chk("lv_rdata2", 64'(unit_rdata[64 +: 32]), 64'hDEAD_BEEF);
        chk("lv_we_a_after", 64'(mem_we_a), 64'h0);
        tick();
        chk("lv_done_clear", 64'(unit_done), 64'h0);

        // STORE_M from unit 1: row 3, col 9, data 2'b10
        set_unit(1, 2'b11, 4'd0, 4'd3, 4'd9, 32'hFFFF_FFF2);
        unit_req = 4'b0010;
        tick();
        tick();
        chk("sm_acc_grant", 64'(unit_grant), 64'h2);
        chk("sm_acc_addr_b", 64'(mem_addr_b), 64'h39);
        chk("sm_acc_we_b", 64'(mem_we_b), 64'h1);
        chk("sm_acc_we_a", 64'(mem_we_a), 64'h0);
        chk("sm_acc_wdata_b", 64'(mem_wdata_b), 64'h2);
        unit_req = 4'b0000;
        tick();
        chk("sm_wait_we_b", 64'(mem_we_b), 64'h0);
        tick();
        chk("sm_done", 64'(unit_done), 64'h2);
        chk("sm_rdata1", 64'(unit_rdata[32 +: 32]), 64'h0);
        tick();

        // Round robin with all four requesting; pointer sits at 2 after unit 1
        for (int i = 0; i < 4; i++) begin
            set_unit(i, 2'b00, 4'(i + 8), 4'd0, 4'd0, 32'h0);
            cnt[i] = 0;
        end
        unit_req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            u = (2 + t) % 4;
            wait_pulse(12, d, e, cyc);
            chk("rr_bound", 64'(cyc < 12), 64'h1);
            chk("rr_order", 64'(d), 64'(4'b0001 << u));
            chk("rr_rdata", 64'(unit_rdata[u*32 +: 32]), 64'(vmem[u*16 + u + 8]));
            for (int k = 0; k < 4; k++) if (d[k]) cnt[k]++;
        end
        unit_req = 4'b0000;
        for (int k = 0; k < 4; k++) chk("rr_count", 64'(cnt[k]), 64'd2);
        tick();

        // Busy timeout on unit 0 (pointer at 2, only unit 0 asks)
        set_unit(0, 2'b00, 4'd1, 4'd0, 4'd0, 32'h0);
        mem_busy = 1'b1;
        unit_req = 4'b0001;
        tick();
        tick();
        chk("to_acc_grant", 64'(unit_grant), 64'h1);
        unit_req = 4'b0000;
        wait_pulse(400, d, e, cyc);
        chk("to_bound", 64'(cyc < 400), 64'h1);
        chk("to_cycles", 64'(cyc == 256 || cyc == 257), 64'h1);
        chk("to_err", 64'(e), 64'h1);
        chk("to_no_done", 64'(d), 64'h0);
        chk("to_err_code", 64'(err_code), 64'h2);
        chk("to_grant", 64'(unit_grant), 64'h0);
        mem_busy = 1'b0;
        tick();
        chk("to_err_clear", 64'(unit_err), 64'h0);

        // Next request after timeout is served normally
        set_unit(1, 2'b00, 4'd2, 4'd0, 4'd0, 32'h0);
        unit_req = 4'b0010;
        wait_pulse(12, d, e, cyc);
        unit_req = 4'b0000;
        chk("post_to_done", 64'(d), 64'h2);
        chk("post_to_rdata1", 64'(unit_rdata[32 +: 32]), 64'(vmem[8'h12]));
        chk("post_to_err_code", 64'(err_code), 64'h2);
        tick();

        // mem_error on the cycle busy drops outranks completion (LOAD_M, unit 3)
        old3 = vmem[3*16 + 11];
        set_unit(3, 2'b10, 4'd0, 4'd4, 4'd7, 32'h0);
        mem_busy = 1'b1;
        unit_req = 4'b1000;
        tick();
        tick();
        chk("me_acc_grant", 64'(unit_grant), 64'h8);
        chk("me_acc_addr_b", 64'(mem_addr_b), 64'h47);
        unit_req = 4'b0000;
        tick();
        tick();
        mem_busy  = 1'b0;
        mem_error = 2'b01;
        tick();
        chk("me_err", 64'(unit_err), 64'h8);
        chk("me_no_done", 64'(unit_done), 64'h0);
        chk("me_err_code", 64'(err_code), 64'h1);
        chk("me_rdata3", 64'(unit_rdata[96 +: 32]), 64'(old3));
        mem_error = 2'b00;
        tick();
        chk("me_err_clear", 64'(unit_err), 64'h0);

        // Reset during WAIT on unit 1, which leaves the pointer at 2 if not cleared
        set_unit(1, 2'b00, 4'd4, 4'd0, 4'd0, 32'h0);
        mem_busy = 1'b1;
        unit_req = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        chk("rw_grant_pre", 64'(unit_grant), 64'h2);
        rst = 1'b1;
        #1;
        chk("rw_grant", 64'(unit_grant), 64'h0);
        chk("rw_rdata", 64'(|unit_rdata), 64'h0);
        chk("rw_err_code", 64'(err_code), 64'h0);
        chk("rw_addr", 64'({mem_addr_a, mem_addr_b}), 64'h0);
        @(negedge clk);
        rst      = 1'b0;
        mem_busy = 1'b0;
        set_unit(3, 2'b00, 4'd6, 4'd0, 4'd0, 32'h0);
        unit_req = 4'b1010;
        tick();
        chk("rw_no_pulse", 64'({unit_done, unit_err}), 64'h0);
        tick();
        chk("rw_first_grant", 64'(unit_grant), 64'h2);
        unit_req = 4'b1000;
        wait_pulse(12, d, e, cyc);
        chk("rw_done1", 64'(d), 64'h2);
        wait_pulse(12, d, e, cyc);
        unit_req = 4'b0000;
        chk("rw_done3", 64'(d), 64'h8);
        chk("rw_rdata3", 64'(unit_rdata[96 +: 32]), 64'(vmem[8'h36]));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Parametrised next-generation arbiter/controller between NUM_UNITS compute units and the shared vector (port A) and matrix (port B) memories.
- Adds over the previous controller:
  - true rotating round-robin fairness;
  - separate vector and matrix load/store operations;
  - a busy-timeout watchdog;
  - per-unit error reporting with a sticky cause code.
- Sits between the unit array and the shared memory macro in the accelerator top level.

Parameters:
- NUM_UNITS, 4, number of requesting units (2..16).
- UID_W, $clog2(NUM_UNITS), unit id width.
- DATA_W, 32, vector word width (port A data).
- IDX_W, 4, per-unit vector index width.
- VADDR_W, UID_W+IDX_W, port A address width, formed as {unit_id, vec_index}.
- MROW_W, 4, matrix row index width.
- MCOL_W, 4, matrix column index width.
- MDATA_W, 2, matrix element width (port B data).
- TIMEOUT, 255, maximum consecutive mem_busy cycles in WAIT before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- unit_req  in  NUM_UNITS  request, level, one bit per unit.
- unit_op  in  NUM_UNITS*2  per-unit op: 00 LOAD_V, 01 STORE_V, 10 LOAD_M, 11 STORE_M.
- unit_vidx  in  NUM_UNITS*IDX_W  vector index.
- unit_mrow  in  NUM_UNITS*MROW_W  matrix row.
- unit_mcol  in  NUM_UNITS*MCOL_W  matrix column.
- unit_wdata  in  NUM_UNITS*DATA_W  write data; matrix stores use bits [MDATA_W-1:0].
- unit_grant  out  NUM_UNITS  one-hot; high from ACCESS through WAIT.
- unit_done  out  NUM_UNITS  one-cycle completion pulse.
- unit_err  out  NUM_UNITS  one-cycle abort pulse.
- unit_rdata  out  NUM_UNITS*DATA_W  per-unit read-data register; matrix loads zero-extended.
- err_code  out  2  sticky last error cause: 01 mem_error, 10 timeout.
- mem_addr_a  out  VADDR_W; mem_we_a out 1; mem_wdata_a out DATA_W; mem_rdata_a in DATA_W.
- mem_addr_b  out  MROW_W+MCOL_W, formed as {row, col}; mem_we_b out 1; mem_wdata_b out MDATA_W; mem_rdata_b in MDATA_W.
- mem_busy  in  1  memory not ready.
- mem_error  in  2  nonzero indicates a memory fault.

Behaviour:
- Reset (async, rst=1): state IDLE; rr_ptr=0; all outputs 0, including unit_rdata, err_code and mem address/data.
  - Reset mid-transaction abandons the access with no done/err pulse.
- All outputs are registered.
- States: IDLE, ARB, ACCESS, WAIT, DONE, ERROR.
- IDLE: if |unit_req, go to ARB; otherwise hold.
- ARB:
  - Select the first requesting unit scanning from rr_ptr upward, wrapping modulo NUM_UNITS.
  - Latch sel, op, addresses and wdata.
  - Set rr_ptr = (sel+1) mod NUM_UNITS.
  - Go to ACCESS.
  - If every request has dropped by ARB, return to IDLE; rr_ptr is unchanged.
- ACCESS (exactly one cycle):
  - Drive mem_addr_a = {sel, vidx} and mem_addr_b = {row, col}.
  - Assert the write enable for the latched op only: mem_we_a for STORE_V, mem_we_b for STORE_M.
  - wdata goes to the matching port.
  - unit_grant[sel] = 1.
  - Go to WAIT with timeout counter = 0.
- WAIT:
  - Both write enables are 0; addresses are held.
  - When mem_busy=0:
    - LOAD_V: capture mem_rdata_a into unit_rdata[sel].
    - LOAD_M: capture zero-extended mem_rdata_b into unit_rdata[sel].
    - Stores: unit_rdata is unchanged.
    - Go to DONE.
  - Each cycle with mem_busy=1 increments the counter. On the cycle the counter equals TIMEOUT, set err_code=10 and go to ERROR.
- DONE: unit_done[sel]=1 for one cycle; unit_grant cleared; go to IDLE.
- ERROR: unit_err[sel]=1 for one cycle; grant cleared; go to IDLE; rr_ptr is kept.
- mem_error:
  - Nonzero in ACCESS or WAIT forces ERROR with err_code=01.
  - This has priority over completion and over timeout in the same cycle.
  - mem_error is ignored in IDLE, ARB, DONE and ERROR.
- Transaction latching: once latched in ARB, the transaction completes regardless of later changes on unit_req, unit_op or the unit address/data inputs.
- Latency with mem_busy=0: request sampled in IDLE at edge E0 → ARB after E0 → ACCESS after E1 → WAIT after E2 → unit_done high after E3 for one cycle. A back-to-back request re-enters ARB one cycle after DONE.
- Fairness: a continuously requesting unit waits at most NUM_UNITS-1 transactions before being served.
- err_code is cleared only by reset.
- At most one unit_grant, unit_done or unit_err bit is high at any time.

Test Plan:
- LOAD_V, unit 2: vidx=5, memory word 0xDEADBEEF at addr {2,5}=0x25, mem_busy=0 → mem_addr_a=0x25 in ACCESS; unit_done[2] pulses 3 edges after request sampled; unit_rdata[2]=0xDEADBEEF.
- STORE_M, unit 1: row=3, col=9, wdata=2'b10 → mem_addr_b=0x39, mem_we_b=1 for exactly one cycle, mem_we_a=0; unit_done[1] pulses.
- All 4 units requesting continuously → grant order 0,1,2,3,0,1…; each unit_done pulses exactly once per 4 transactions.
- mem_busy held high with TIMEOUT=255 → unit_err[sel] pulses after 255 busy cycles; err_code=10; no unit_done; the next request is served normally.
- mem_error=01 asserted in WAIT on the same cycle mem_busy drops → ERROR wins: unit_err pulses, err_code=01, unit_rdata unchanged.
- rst asserted during WAIT → all outputs 0 immediately; after release, a request from unit 3 is granted with rr_ptr restarting at 0.
